// File: rtl/multiword_add_seq.sv
// Sequential wide adder/subtractor: one N-bit chunk per clock, LSB chunk first.
// Define MULTIWORD_FLAGS_EN to add registered zero and signed-overflow flags.
module multiword_add_seq #(
  parameter int unsigned N     = 4,
  parameter int unsigned WORDS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic               c_in,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] sum,
  output logic               c_out
`ifdef MULTIWORD_FLAGS_EN
  ,
  output logic               zero,
  output logic               ovf
`endif
);

  localparam int unsigned W    = N * WORDS;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state;
  logic [IdxW-1:0] r_idx;
  logic            r_carry;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_c_out;
  logic            r_out_valid;

  logic [N-1:0]    w_chunk_a;
  logic [N-1:0]    w_chunk_b;
  logic [N:0]      w_add;
  logic [W-1:0]    w_sum_next;

`ifdef MULTIWORD_FLAGS_EN
  logic            r_zero;
  logic            r_ovf;
  logic            w_ovf;
`endif

  // N+1-bit chunk add keeps the carry-out; the updated sum image feeds the zero flag.
  always_comb begin
    w_chunk_a  = r_a[r_idx*N +: N];
    w_chunk_b  = r_b[r_idx*N +: N];
    w_add      = {1'b0, w_chunk_a} + {1'b0, w_chunk_b} + {{N{1'b0}}, r_carry};
    w_sum_next = r_sum;
    w_sum_next[r_idx*N +: N] = w_add[N-1:0];
  end

`ifdef MULTIWORD_FLAGS_EN
  // Carry into the MSB is recovered as a ^ b ^ s at that bit.
  assign w_ovf = w_chunk_a[N-1] ^ w_chunk_b[N-1] ^ w_add[N-1] ^ w_add[N];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_c_out     <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef MULTIWORD_FLAGS_EN
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? ~c_in : c_in;
            r_idx   <= '0;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_sum   <= w_sum_next;
          r_carry <= w_add[N];
          if (r_idx == LastIdx) begin
            r_c_out     <= w_add[N];
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
`ifdef MULTIWORD_FLAGS_EN
            r_zero      <= (w_sum_next == '0);
            r_ovf       <= w_ovf;
`endif
          end else begin
            r_idx <= r_idx + IdxW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign c_out     = r_c_out;
`ifdef MULTIWORD_FLAGS_EN
  assign zero      = r_zero;
  assign ovf       = r_ovf;
`endif

endmodule
